// File: rtl/priority_arbiter_pkg.sv
// Shared widths, sizes and FSM state type for the priority arbiter and its encoder.
package priority_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;
    localparam int HOLD_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/priority_arbiter_rotating_priority_encoder.sv
// Combinational winner search: descending from a start index with wrap-around.
// In fixed mode the start is forced to the top index, so req[7] always wins.
module rotating_priority_encoder
    import priority_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start_idx,
    input  logic               rr_mode,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    logic [ID_W-1:0] w_start;
    logic [ID_W-1:0] w_idx;

    // Walk lowest priority first so the last hit (i = 0, the start index) wins.
    always_comb begin
        w_start = rr_mode ? start_idx : ID_W'(NUM_REQ - 1);
        w_idx   = '0;
        id      = '0;
        any     = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = w_start - ID_W'(i);
            if (req[w_idx]) begin
                id  = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Two-state arbiter: picks one requester in IDLE, holds it in GRANT until release,
// request drop or MAX_HOLD cycles, always leaving one idle bubble between grants.
module priority_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic                                  rr_mode,
    // "release" is a reserved word, hence the suffix.
    input  logic                                  release_in,
    output logic [NUM_REQ-1:0]                    gnt,
    output logic [priority_arbiter_pkg::ID_W-1:0] gnt_id,
    output logic                                  gnt_valid,
    output logic                                  timeout,
    output priority_arbiter_pkg::state_t          dbg_state
);
    import priority_arbiter_pkg::*;

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    state_t              r_state,    w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt,      w_gnt_nxt;
    logic [ID_W-1:0]     r_gnt_id,   w_gnt_id_nxt;
    logic                r_valid,    w_valid_nxt;
    logic                r_timeout,  w_timeout_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
    logic [ID_W-1:0]     r_last_id,  w_last_nxt;

    logic [ID_W-1:0]     w_win;
    logic                w_any;

    // Starting one below the previous winner makes the previous winner lowest priority.
    rotating_priority_encoder u_enc (
        .req       (req),
        .start_idx (r_last_id - ID_W'(1)),
        .rr_mode   (rr_mode),
        .id        (w_win),
        .any       (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
            r_last_id  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_valid    <= w_valid_nxt;
            r_timeout  <= w_timeout_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last_id  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = '0;
        w_gnt_id_nxt  = '0;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        w_hold_nxt    = '0;
        w_last_nxt    = r_last_id;
        case (r_state)
            IDLE: begin
                if (en && w_any) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = NUM_REQ'(1) << w_win;
                    w_gnt_id_nxt = w_win;
                    w_valid_nxt  = 1'b1;
                    w_hold_nxt   = HOLD_W'(1);
                    w_last_nxt   = w_win;
                end
            end
            GRANT: begin
                // Release wins over the hold limit, so a release at MAX_HOLD raises no timeout.
                if (release_in || !req[r_gnt_id]) begin
                    w_state_nxt = IDLE;
                end else if (r_hold_cnt >= MAX_HOLD_C) begin
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_gnt_nxt    = r_gnt;
                    w_gnt_id_nxt = r_gnt_id;
                    w_valid_nxt  = 1'b1;
                    w_hold_nxt   = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_valid;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench for priority_arbiter: a cycle model pushes expected outputs
// per driven cycle; they are popped and compared one clock later.
module tb_priority_arbiter;
  import priority_arbiter_pkg::*;

  localparam int MAX_HOLD = 15;

  // clock / reset / DUT
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rr_mode = 1'b0;
  logic       rel = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  state_t     dbg_state;

  always #5 clk = ~clk;

  priority_arbiter #(.NUM_REQ(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .rr_mode    (rr_mode),
    .release_in (rel),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid),
    .timeout    (timeout),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [12:0] exp_q[$];  // {valid, id[2:0], gnt[7:0], timeout}
  int id_log[$];
  int to_count;
  int valid_run;
  int max_run;

  // reference model state
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_cycle(output logic [12:0] e);
    int w;
    int idx;
    w = -1;
    e = '0;
    if (rst) begin
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 0;
    end else if (m_owner < 0) begin
      if (en && req != 8'h00) begin
        if (!rr_mode) begin
          for (int k = 7; k >= 0; k--)
            if (w < 0 && req[k]) w = k;
        end else begin
          for (int k = 1; k <= 8; k++) begin
            idx = (m_last - k + 16) % 8;
            if (w < 0 && req[idx]) w = idx;
          end
        end
        m_owner = w;
        m_cnt   = 1;
        m_last  = w;
        e = {1'b1, 3'(w), 8'(1 << w), 1'b0};
      end
    end else if (rel || !req[m_owner]) begin
      m_owner = -1;
      m_cnt   = 0;
    end else if (m_cnt == MAX_HOLD) begin
      m_owner = -1;
      m_cnt   = 0;
      e[0]    = 1'b1;
    end else begin
      m_cnt++;
      e = {1'b1, 3'(m_owner), 8'(1 << m_owner), 1'b0};
    end
  endtask

  // driver: one clock with the current inputs
  task automatic step();
    logic [12:0] e;
    logic [12:0] x;
    logic [12:0] got;
    model_cycle(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    got = {gnt_valid, gnt_id, gnt, timeout};
    chk("outputs", 32'(got), 32'(x));
    chk("state", 32'(dbg_state), {31'b0, x[12]});
    if (gnt_valid) begin
      id_log.push_back(int'(gnt_id));
      valid_run++;
      if (valid_run > max_run) max_run = valid_run;
    end else begin
      valid_run = 0;
    end
    if (timeout) to_count++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rel = 1'b0;
    step();
    step();
    rst = 1'b0;
    id_log.delete();
    to_count  = 0;
    valid_run = 0;
    max_run   = 0;
  endtask

  int exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  initial begin
    // reset state
    en = 1'b1;
    req = 8'hFF;
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);

    // fixed mode, release at 3rd grant cycle
    rr_mode = 1'b0;
    req = 8'b0010_0100;
    for (int i = 0; i < 12; i++) begin
      rel = (m_owner >= 0 && m_cnt == 3);
      step();
    end
    rel = 1'b0;
    chk("fixed_grants", 32'(id_log.size()), 32'd9);
    chk("fixed_id0", 32'(id_log[0]), 32'd5);
    chk("fixed_id3", 32'(id_log[3]), 32'd5);

    // round-robin, release every grant cycle
    do_reset();
    rr_mode = 1'b1;
    req = 8'hFF;
    rel = 1'b1;
    for (int i = 0; i < 18; i++) step();
    rel = 1'b0;
    chk("rr_grants", 32'(id_log.size()), 32'd9);
    for (int i = 0; i < 9 && i < id_log.size(); i++)
      chk("rr_seq", 32'(id_log[i]), 32'(exp_seq[i]));

    // hold limit with no release
    do_reset();
    rr_mode = 1'b0;
    req = 8'h08;
    for (int i = 0; i < 40; i++) step();
    chk("hold_timeouts", 32'(to_count), 32'd2);
    chk("hold_maxrun", 32'(max_run), 32'd15);

    // release in the 15th grant cycle beats the timeout
    do_reset();
    req = 8'h08;
    for (int i = 0; i < 20; i++) begin
      rel = (m_owner >= 0 && m_cnt == 15);
      step();
    end
    rel = 1'b0;
    chk("rel15_timeouts", 32'(to_count), 32'd0);
    chk("rel15_maxrun", 32'(max_run), 32'd15);

    // reset in the 2nd grant cycle
    do_reset();
    req = 8'h80;
    for (int i = 0; i < 10; i++) begin
      rst = (m_owner >= 0 && m_cnt == 2);
      step();
    end
    rst = 1'b0;
    chk("midrst_maxrun", 32'(max_run), 32'd2);

    // enable gating
    do_reset();
    en = 1'b0;
    req = 8'h01;
    for (int i = 0; i < 4; i++) step();
    chk("en0_nogrant", 32'(id_log.size()), 32'd0);
    en = 1'b1;
    step();
    chk("en1_gnt", 32'(gnt), 32'h01);
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("en_drop_hold", 32'(gnt_valid), 32'd1);
    rel = 1'b1;
    step();
    rel = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("en_total", 32'(id_log.size()), 32'd6);

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      rr_mode = $urandom_range(0, 1);
      rel     = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 39) == 0);
      req     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      step();
    end
    rst = 1'b0;
    rel = 1'b0;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
